post_tu: RTL and testbench
==========================

Name: post_tu

Overview:
Winograd output (inverse) transform unit, the counterpart of the input pre-transform stage.
- Takes the element-wise product tile M (after the PE multiply stage) one row per cycle.
- Applies the inverse transform A^T·M·A and streams the spatial output tile, one row per cycle, saturated back to activation width.
- Two modes, matching the pre-transform: RFConv (4x4 tile in, 2x2 out) and deconv (6x6 tile in, 4x4 out).

Parameters:
A_bits, 12, output activation width (signed); outputs saturate to this width
P_bits, 24, input product width (signed)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input row valid
in_ready  output  1  block can accept a row
in_mode  input  1  1 = RFConv, 0 = deconv; sampled only on the first row of a tile
in_row[5:0]  input  P_bits each, signed  product row; RFConv uses [3:0], [5:4] ignored
out_valid  output  1  output row valid
out_ready  input  1  downstream accepts the row
out_row[3:0]  output  A_bits each, signed  output row; RFConv drives [1:0], [3:2] = 0
out_last  output  1  high with the final row of a tile
out_sat  output  1  high with a row in which any element was clamped
busy  output  1  a tile is partially collected or being emitted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state becomes COLLECT with row count 0; the stored tile is cleared.
  - out_valid, out_last, out_sat and busy are 0; out_row = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after rst falls.
- FSM states: COLLECT, EMIT.
- COLLECT:
  - in_ready = 1. A row is accepted when in_valid && in_ready.
  - On the first row (count 0), in_mode is latched into tile_mode. in_mode is ignored on later rows of the tile.
  - Row transform is applied on acceptance; the result is stored at intermediate index = count.
    - RFConv: r0 = m0+m1+m2, r1 = m1-m2-m3. Each result is P_bits+2 wide.
    - Deconv: r0 = m0+m1, r1 = m1+m2, r2 = m3+m4, r3 = m4+m5. Each result is P_bits+1 wide.
  - busy = 1 whenever count > 0.
  - When the last row is accepted (count 3 for RFConv, count 5 for deconv), go to EMIT the next cycle and reset count to 0.
- EMIT:
  - in_ready = 0, busy = 1, out_valid = 1.
  - Output row k is computed from column k of the intermediate array using the same formulas applied down the columns.
    - RFConv: row0 = R0+R1+R2, row1 = R1-R2-R3, elementwise over 2 columns. 2 output rows.
    - Deconv: row0 = R0+R1, row1 = R1+R2, row2 = R3+R4, row3 = R4+R5, elementwise over 4 columns. 4 output rows.
  - Full-precision sums are kept (RFConv P_bits+4, deconv P_bits+2), then each element saturates to [-2^(A_bits-1), 2^(A_bits-1)-1].
  - out_sat = OR over the row's clamp flags.
  - A row advances only when out_valid && out_ready. While out_ready = 0, out_row, out_last and out_sat hold stable.
  - out_last = 1 on row 1 (RFConv) or row 3 (deconv).
  - After the last row handshakes, go to COLLECT; in_ready = 1 on the next cycle.
- Latency: out_valid rises exactly 1 cycle after the last input row is accepted.
- No overlap: the next tile cannot be accepted while EMIT is active.
- Outputs while out_valid = 0: out_row = 0, out_last = 0, out_sat = 0.
- Reset mid-operation (COLLECT or EMIT): the tile is discarded, no further output is produced, and the reset values above apply.
- An in_valid gap between rows does not advance count.

Test Plan:
- RFConv, all M = 1, 4 back-to-back rows, out_ready = 1 -> row0 = [9,-3,0,0], row1 = [-3,1,0,0] with out_last, out_sat = 0; out_valid rises 1 cycle after the 4th row.
- Deconv, all M = 1, 6 rows -> 4 rows of [4,4,4,4], out_last on the 4th row, then in_ready = 1.
- RFConv, all M = 1000 with A_bits = 12 -> row0 = [2047,-2048] with out_sat = 1; row1 = [-2048,1000] with out_sat = 1.
- Backpressure: deconv tile, out_ready held 0 for 3 cycles on row1 -> row1 stable all 3 cycles; in_ready stays 0; all 4 rows are emitted exactly once.
- Mode latching: first row with in_mode = 1, later rows with in_mode = 0 -> the tile is treated as RFConv (4 rows in, 2 rows out).
- Reset mid-collection: 2 rows accepted, rst pulsed 1 cycle -> busy = 0, in_ready = 1 the next cycle; a fresh all-ones RFConv tile then yields [9,-3] / [-3,1].

Source files
------------

// File: rtl/post_tu.sv
// Winograd inverse (output) transform: collects the product tile M row by row, applies A^T*M*A,
// and streams saturated spatial output rows. RFConv: 4x4 -> 2x2, deconv: 6x6 -> 4x4.
module post_tu #(
  parameter int unsigned A_bits = 12,
  parameter int unsigned P_bits = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [5:0][P_bits-1:0]   in_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0][A_bits-1:0]   out_row,
  output logic                     out_last,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int unsigned IW = P_bits + 2;
  localparam int unsigned SW = P_bits + 4;
  localparam logic signed [SW-1:0] SatMax = $signed(SW'((64'd1 << (A_bits - 1)) - 64'd1));
  localparam logic signed [SW-1:0] SatMin = ~SatMax;

  typedef enum logic {StCollect, StEmit} state_e;

  state_e              state_q;
  logic [2:0]          cnt_q;
  logic                mode_q;
  logic signed [IW-1:0] tile_q [6][4];

  logic signed [IW-1:0] m  [6];
  logic signed [IW-1:0] rt [4];
  logic signed [SW-1:0] sum [4];
  logic                 row_mode;
  logic                 accept;
  logic                 last_in;
  logic                 last_out;

  function automatic logic signed [SW-1:0] ext(input logic signed [IW-1:0] x);
    return {{(SW - IW){x[IW-1]}}, x};
  endfunction

  // Row transform of the incoming product row (first pass of A^T*M*A).
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      m[i] = {{(IW - P_bits){in_row[i][P_bits-1]}}, in_row[i]};
    end
    row_mode = (cnt_q == 3'd0) ? in_mode : mode_q;
    if (row_mode) begin
      rt[0] = m[0] + m[1] + m[2];
      rt[1] = m[1] - m[2] - m[3];
      rt[2] = '0;
      rt[3] = '0;
    end else begin
      rt[0] = m[0] + m[1];
      rt[1] = m[1] + m[2];
      rt[2] = m[3] + m[4];
      rt[3] = m[4] + m[5];
    end
    in_ready = (state_q == StCollect) && !rst;
    accept   = in_valid && in_ready;
    last_in  = row_mode ? (cnt_q == 3'd3) : (cnt_q == 3'd5);
    last_out = mode_q ? (cnt_q == 3'd1) : (cnt_q == 3'd3);
  end

  // Column transform for the output row selected by cnt_q (second pass).
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      sum[c] = '0;
    end
    if (mode_q) begin
      for (int c = 0; c < 2; c++) begin
        case (cnt_q)
          3'd0:    sum[c] = ext(tile_q[0][c]) + ext(tile_q[1][c]) + ext(tile_q[2][c]);
          default: sum[c] = ext(tile_q[1][c]) - ext(tile_q[2][c]) - ext(tile_q[3][c]);
        endcase
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        case (cnt_q)
          3'd0:    sum[c] = ext(tile_q[0][c]) + ext(tile_q[1][c]);
          3'd1:    sum[c] = ext(tile_q[1][c]) + ext(tile_q[2][c]);
          3'd2:    sum[c] = ext(tile_q[3][c]) + ext(tile_q[4][c]);
          default: sum[c] = ext(tile_q[4][c]) + ext(tile_q[5][c]);
        endcase
      end
    end
  end

  // Output decode with saturation; everything reads as zero outside EMIT.
  always_comb begin
    out_valid = (state_q == StEmit);
    busy      = (state_q == StEmit) || (cnt_q != 3'd0);
    out_last  = out_valid && last_out;
    out_sat   = 1'b0;
    out_row   = '0;
    if (out_valid) begin
      for (int c = 0; c < 4; c++) begin
        if (sum[c] > SatMax) begin
          out_row[c] = SatMax[A_bits-1:0];
          out_sat    = 1'b1;
        end else if (sum[c] < SatMin) begin
          out_row[c] = SatMin[A_bits-1:0];
          out_sat    = 1'b1;
        end else begin
          out_row[c] = sum[c][A_bits-1:0];
        end
      end
    end
  end

  // cnt_q counts collected rows in COLLECT and is the output row index in EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 4; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        StCollect: begin
          if (accept) begin
            for (int r = 0; r < 6; r++) begin
              if (cnt_q == 3'(r)) begin
                for (int c = 0; c < 4; c++) begin
                  tile_q[r][c] <= rt[c];
                end
              end
            end
            if (cnt_q == 3'd0) begin
              mode_q <= in_mode;
            end
            if (last_in) begin
              state_q <= StEmit;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            if (last_out) begin
              state_q <= StCollect;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

endmodule

// File: tb/tb_post_tu.sv
// Bench for post_tu: directed literal tiles plus randomized tiles checked every cycle against a
// matrix-product model of A^T*M*A with saturation.
module tb_post_tu;
  localparam int A = 12;
  localparam int P = 24;
  localparam longint Hi = 2 ** (A - 1) - 1;
  localparam longint Lo = -(2 ** (A - 1));

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_mode = 1'b0;
  logic [5:0][P-1:0]  in_row = '0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [3:0][A-1:0]  out_row;
  logic               out_last;
  logic               out_sat;
  logic               busy;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  longint stim [6][6];

  typedef struct {
    longint v [4];
    bit     last;
    bit     sat;
  } exp_t;

  exp_t   expq [$];
  longint mcol [6][6];
  int     mcnt = 0;
  bit     mmode = 1'b0;

  post_tu #(.A_bits(A), .P_bits(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_last (out_last),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Y = AT * M * AT^T with AT the inverse-transform matrix of the latched mode.
  function automatic void build_expect();
    int     n, o;
    int     at [4][6];
    longint t [4][6];
    longint y;
    exp_t   e;
    n = mmode ? 4 : 6;
    o = mmode ? 2 : 4;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 6; k++) at[i][k] = 0;
    if (mmode) begin
      at[0][0] = 1; at[0][1] = 1; at[0][2] = 1;
      at[1][1] = 1; at[1][2] = -1; at[1][3] = -1;
    end else begin
      at[0][0] = 1; at[0][1] = 1; at[1][1] = 1; at[1][2] = 1;
      at[2][3] = 1; at[2][4] = 1; at[3][4] = 1; at[3][5] = 1;
    end
    for (int i = 0; i < o; i++) begin
      for (int j = 0; j < n; j++) begin
        t[i][j] = 0;
        for (int k = 0; k < n; k++) t[i][j] += at[i][k] * mcol[k][j];
      end
    end
    for (int i = 0; i < o; i++) begin
      e.sat = 1'b0;
      for (int j = 0; j < 4; j++) e.v[j] = 0;
      for (int j = 0; j < o; j++) begin
        y = 0;
        for (int k = 0; k < n; k++) y += t[i][k] * at[j][k];
        if (y > Hi) begin y = Hi; e.sat = 1'b1; end
        if (y < Lo) begin y = Lo; e.sat = 1'b1; end
        e.v[j] = y;
      end
      e.last = (i == o - 1);
      expq.push_back(e);
    end
  endfunction

  // Per-cycle compare against the model, then fold this cycle's handshakes into it.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      mcnt = 0;
    end else begin
      check("in_ready", in_ready, expq.size() == 0);
      check("busy", busy, (mcnt > 0) || (expq.size() > 0));
      check("out_valid", out_valid, expq.size() > 0);
      if (out_valid && expq.size() > 0) begin
        for (int c = 0; c < 4; c++) begin
          check($sformatf("out_row[%0d]", c), longint'($signed(out_row[c])), expq[0].v[c]);
        end
        check("out_last", out_last, expq[0].last);
        check("out_sat", out_sat, expq[0].sat);
        if (out_ready) void'(expq.pop_front());
      end else if (!out_valid) begin
        check("idle outputs", longint'({out_last, out_sat, out_row}), 0);
      end
      if (in_valid && in_ready) begin
        if (mcnt == 0) mmode = in_mode;
        for (int c = 0; c < 6; c++) mcol[mcnt][c] = longint'($signed(in_row[c]));
        mcnt++;
        if (mcnt == (mmode ? 4 : 6)) begin
          build_expect();
          mcnt = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic fill_const(input longint v);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) stim[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if ($urandom_range(0, 3) == 0) stim[r][c] = longint'($signed(P'($urandom)));
        else stim[r][c] = longint'($urandom_range(0, 4000)) - 2000;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the row is accepted.
  task automatic send_row(input bit mode, input int r, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_mode  = mode;
    for (int c = 0; c < 6; c++) in_row[c] = P'(stim[r][c]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (n >= 200) check("in_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input bit mode);
    for (int r = 0; r < (mode ? 4 : 6); r++) send_row(mode, r, 0);
  endtask

  task automatic expect_row(input string name, input longint e0, input longint e1,
                            input longint e2, input longint e3, input bit last, input bit sat);
    @(negedge clk);
    check({name, " valid"}, out_valid, 1);
    check({name, " r0"}, longint'($signed(out_row[0])), e0);
    check({name, " r1"}, longint'($signed(out_row[1])), e1);
    check({name, " r2"}, longint'($signed(out_row[2])), e2);
    check({name, " r3"}, longint'($signed(out_row[3])), e3);
    check({name, " last"}, out_last, last);
    check({name, " sat"}, out_sat, sat);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_valid || busy) && n < 1000);
    if (n >= 1000) check("idle timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("rst in_ready", in_ready, 0);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst outs", longint'({out_last, out_sat, out_row}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    fill_const(1);
    send_tile(1'b1);
    expect_row("rf ones row0", 9, -3, 0, 0, 1'b0, 1'b0);
    expect_row("rf ones row1", -3, 1, 0, 0, 1'b1, 1'b0);

    fill_const(1);
    send_tile(1'b0);
    for (int k = 0; k < 4; k++) expect_row("dc ones", 4, 4, 4, 4, k == 3, 1'b0);
    @(negedge clk);
    check("dc ones in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    fill_const(1000);
    send_tile(1'b1);
    expect_row("rf sat row0", 2047, -2048, 0, 0, 1'b0, 1'b1);
    expect_row("rf sat row1", -2048, 1000, 0, 0, 1'b1, 1'b1);

    // Backpressure on row1 of a ramp tile M[r][c] = r + c.
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) stim[r][c] = r + c;
    send_tile(1'b0);
    expect_row("bp row0", 4, 8, 16, 20, 1'b0, 1'b0);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp in_ready", in_ready, 0);
      check("bp row1 r0", longint'($signed(out_row[0])), 8);
      check("bp row1 r3", longint'($signed(out_row[3])), 24);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    expect_row("bp row1", 8, 12, 20, 24, 1'b0, 1'b0);
    expect_row("bp row2", 16, 20, 28, 32, 1'b0, 1'b0);
    expect_row("bp row3", 20, 24, 32, 36, 1'b1, 1'b0);

    fill_const(1);
    send_row(1'b1, 0, 0);
    for (int r = 1; r < 4; r++) send_row(1'b0, r, 0);
    expect_row("latch row0", 9, -3, 0, 0, 1'b0, 1'b0);
    expect_row("latch row1", -3, 1, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    check("latch in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send_row(1'b0, 0, 0);
    send_row(1'b0, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send_tile(1'b1);
    expect_row("midrst row0", 9, -3, 0, 0, 1'b0, 1'b0);
    expect_row("midrst row1", -3, 1, 0, 0, 1'b1, 1'b0);

    rand_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      bit mode;
      mode = $urandom_range(0, 1) == 1;
      fill_rand();
      for (int r = 0; r < (mode ? 4 : 6); r++) begin
        send_row((r == 0) ? mode : ($urandom_range(0, 1) == 1), r,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    wait_idle();
    check("final queue empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
